// File: rtl/alu_iter_mul.sv
// EX-stage ALU: single-cycle and/xor/sll/add/sub/addi/srai plus an iterative shift-add mul.
// Latency: 0 cycles for single-cycle ops; mul = 33 cycles (17 with ALU_MUL_2BIT_EN defined).
// Backpressure: stall_o holds the pipeline while a mul is in flight; flush_i aborts it.
module alu_iter_mul (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        zero_o,
    output logic        stall_o
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

`ifdef ALU_MUL_2BIT_EN
    localparam logic [4:0] CNT_LAST = 5'd15;
`else
    localparam logic [4:0] CNT_LAST = 5'd31;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  cnt;

    logic [31:0] mcand_nxt;
    logic [31:0] mplier_nxt;
    logic [31:0] acc_nxt;
    logic [31:0] comb_res;
    logic [4:0]  shamt;
    logic        mul_req;
    logic        start;
    logic        step;

    assign shamt   = data2_i[4:0];
    assign mul_req = valid_i & ~flush_i & (ALUCtrl_i == OP_MUL);

    // The mul code has no single-cycle result; it reads as 0 while IDLE.
    always_comb begin
        comb_res = 32'd0;
        case (ALUCtrl_i)
            OP_AND:  comb_res = data1_i & data2_i;
            OP_XOR:  comb_res = data1_i ^ data2_i;
            OP_SLL:  comb_res = data1_i << shamt;
            OP_ADD:  comb_res = data1_i + data2_i;
            OP_SUB:  comb_res = data1_i - data2_i;
            OP_ADDI: comb_res = data1_i + data2_i;
            OP_SRAI: comb_res = $signed(data1_i) >>> shamt;
            default: comb_res = 32'd0;
        endcase
    end

    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
`ifdef ALU_MUL_2BIT_EN
        acc_nxt    = acc + (mplier[0] ? mcand : 32'd0)
                         + (mplier[1] ? {mcand[30:0], 1'b0} : 32'd0);
        mcand_nxt  = {mcand[29:0], 2'b00};
        mplier_nxt = {2'b00, mplier[31:2]};
`else
        acc_nxt    = acc + (mplier[0] ? mcand : 32'd0);
        mcand_nxt  = {mcand[30:0], 1'b0};
        mplier_nxt = {1'b0, mplier[31:1]};
`endif
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        data_o    = comb_res;
        start     = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (mul_req) begin
                    stall_o   = 1'b1;
                    start     = 1'b1;
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                data_o = 32'd0;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    step    = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Unconditional return keeps the mul still sitting in EX from relaunching here.
                data_o    = acc;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign zero_o = (data_o == 32'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else if (start) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else if (step) begin
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_alu_iter_mul.sv
// Bench for alu_iter_mul: directed literal cases plus randomized traffic against a cycle-timeline model.
module tb_alu_iter_mul;

`ifdef ALU_MUL_2BIT_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        stall_o;

    int vectors     = 0;
    int miscompares = 0;

    alu_iter_mul dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .stall_o   (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a ^ b;
            3'b010:  return a << sh;
            3'b011:  return a + b;
            3'b100:  return a - b;
            3'b110:  return a + b;
            3'b111:  return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Timeline model: a mul accepted at cycle t stalls through t+LAT-1 and shows its product at t+LAT.
    initial begin
        bit          m_busy;
        int          m_k;
        logic [31:0] m_prod;
        bit          exp_s;
        bit          chk_d;
        logic [31:0] exp_d;
        m_busy = 0;
        m_k    = 0;
        m_prod = 32'd0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_s  = 0;
                chk_d  = (ALUCtrl_i != 3'b101);
                exp_d  = ref_alu(ALUCtrl_i, data1_i, data2_i);
                m_busy = 0;
            end else if (!m_busy) begin
                exp_s = valid_i && !flush_i && (ALUCtrl_i == 3'b101);
                chk_d = (ALUCtrl_i != 3'b101);
                exp_d = ref_alu(ALUCtrl_i, data1_i, data2_i);
                if (exp_s) begin
                    m_busy = 1;
                    m_k    = 1;
                    m_prod = data1_i * data2_i;
                end
            end else if (m_k < LAT) begin
                exp_s = !flush_i;
                chk_d = 1;
                exp_d = 32'd0;
                if (flush_i) m_busy = 0;
                else         m_k++;
            end else begin
                exp_s  = 0;
                chk_d  = 1;
                exp_d  = m_prod;
                m_busy = 0;
            end
            check("model_stall", 32'(stall_o), 32'(exp_s));
            if (chk_d) begin
                check("model_data", data_o, exp_d);
                check("model_zero", 32'(zero_o), 32'(exp_d == 32'd0));
            end
        end
    end

    task automatic single_op(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk_i);
        #1;
        valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = op; data1_i = a; data2_i = b;
        #1;
        check({name, "_data"}, data_o, exp);
        check({name, "_stall"}, 32'(stall_o), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+2 of the product cycle with inputs still held.
    task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        bit done;
        n = 0;
        done = 0;
        valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = 3'b101; data1_i = a; data2_i = b;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (stall_o) begin
                n++;
                @(posedge clk_i);
                #1;
            end else begin
                done = 1;
            end
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(LAT));
        check({name, "_product"}, data_o, exp);
        check({name, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] b0;
        int n;
        bit done;
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ALUCtrl_i = 3'b000;
        data1_i = 32'd0; data2_i = 32'd0;
        #1;
        check("reset_stall", 32'(stall_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        single_op("add_ovf", 3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        single_op("sub_eq",  3'b100, 32'd5, 32'd5, 32'h0000_0000);
        check("sub_eq_zero", 32'(zero_o), 32'd1);
        single_op("srai",    3'b111, 32'h8000_0000, 32'd4, 32'hF800_0000);
        single_op("sll_mask", 3'b010, 32'd1, 32'd33, 32'h0000_0002);
        single_op("and",     3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        single_op("xor",     3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        single_op("addi",    3'b110, 32'd10, 32'hFFFF_FFFF, 32'd9);

        @(posedge clk_i); #1;
        do_mul("mul_7x6", 32'd7, 32'd6, 32'd42);
        @(posedge clk_i); #1;
        valid_i = 1'b0; ALUCtrl_i = 3'b011; data1_i = 32'd1; data2_i = 32'd2;
        #1;
        check("after_mul_idle_stall", 32'(stall_o), 32'd0);
        check("after_mul_idle_data", data_o, 32'd3);

        @(posedge clk_i); #1;
        do_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        @(posedge clk_i); #1;
        do_mul("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);

        // Back-to-back: operands held across the product cycle relaunch on the very next cycle.
        @(posedge clk_i); #1;
        do_mul("b2b_first", 32'd3, 32'd5, 32'd15);
        @(posedge clk_i); #1;
        do_mul("b2b_second", 32'd3, 32'd5, 32'd15);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        #1;
        check("b2b_no_restart", 32'(stall_o), 32'd0);

        // Flush at cycle 10 of a mul.
        @(posedge clk_i); #1;
        valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = 3'b101; data1_i = 32'd9; data2_i = 32'd9;
        repeat (10) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; ALUCtrl_i = 3'b011; data1_i = 32'd2; data2_i = 32'd3;
        #1;
        check("flush_idle_stall", 32'(stall_o), 32'd0);
        check("flush_idle_data", data_o, 32'd5);

        // Asynchronous reset mid-multiply.
        @(posedge clk_i); #1;
        ALUCtrl_i = 3'b101; data1_i = 32'd11; data2_i = 32'd13;
        repeat (5) @(posedge clk_i);
        #2;
        check("pre_rst_stall", 32'(stall_o), 32'd1);
        #1;
        rst_i = 1'b1; ALUCtrl_i = 3'b011; data1_i = 32'd10; data2_i = 32'd20;
        #1;
        check("rst_async_stall", 32'(stall_o), 32'd0);
        check("rst_async_data", data_o, 32'd30);
        #3;
        rst_i = 1'b0;
        @(posedge clk_i); #2;
        check("post_rst_add_stall", 32'(stall_o), 32'd0);
        check("post_rst_add_data", data_o, 32'd30);

        // Operands scrambled every cycle during MUL.
        @(posedge clk_i); #1;
        a0 = 32'd123457; b0 = 32'd987;
        valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = 3'b101; data1_i = a0; data2_i = b0;
        n = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (stall_o) begin
                n++;
                @(posedge clk_i); #1;
                data1_i = $urandom; data2_i = $urandom;
            end else begin
                done = 1;
            end
        end
        check("toggle_stall_cycles", 32'(n), 32'(LAT));
        check("toggle_product", data_o, a0 * b0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;

        // Random traffic; the timeline model checks every cycle.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk_i); #1;
            valid_i   = ($urandom % 8) != 0;
            flush_i   = ($urandom % 24) == 0;
            ALUCtrl_i = 3'($urandom);
            case ($urandom % 4)
                0: begin data1_i = 32'($urandom % 16); data2_i = 32'($urandom % 40); end
                1: begin data1_i = $urandom; data2_i = data1_i; end
                default: begin data1_i = $urandom; data2_i = $urandom; end
            endcase
        end

        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        repeat (LAT + 2) @(posedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
